// File: rtl/pwl_act_sched_pkg.sv
// Shared definitions for the PWL activation scheduler: Q8.8 constants and lane-ID sizing.
package pwl_act_sched_pkg;

    localparam int PWL_DATA_W = 16;

    localparam logic signed [15:0] Q88_ZERO = 16'sh0000;
    localparam logic signed [15:0] Q88_HALF = 16'sh0080;
    localparam logic signed [15:0] Q88_ONE  = 16'sh0100;

    // A single-lane build still needs a 1-bit ID field.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwl_act_sched_if.sv
// Requester, PWL-unit and response signals of the scheduler, grouped with directional views.
interface pwl_act_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) ();
    import pwl_act_sched_pkg::*;

    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_x;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      pwl_valid_in;
    logic [DATA_W-1:0]         pwl_x_in;
    logic                      pwl_valid_out;
    logic [DATA_W-1:0]         pwl_y_out;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_y;
    logic [CNT_W-1:0]          issue_cnt;
    logic                      desync_err;

    // Requesters plus the PWL unit's result side.
    modport master (
        output req_valid, req_x, pwl_valid_out, pwl_y_out,
        input  req_ready, pwl_valid_in, pwl_x_in, rsp_valid, rsp_id, rsp_y,
               issue_cnt, desync_err
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_x, pwl_valid_out, pwl_y_out,
        output req_ready, pwl_valid_in, pwl_x_in, rsp_valid, rsp_id, rsp_y,
               issue_cnt, desync_err
    );

endinterface

// File: rtl/pwl_act_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting lane at or after the pointer wins.
module rr_arbiter import pwl_act_sched_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin : p_arb
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/pwl_act_sched.sv
// Time-shares one PWL activation unit between NUM_REQ lanes; tags issued ops and
// routes each result back to its lane.
module pwl_act_sched import pwl_act_sched_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = PWL_DATA_W,
    parameter int PWL_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    pwl_act_sched_if.slave   bus
);

    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [DATA_W-1:0]  w_x;

    logic [ID_W-1:0]    r_ptr;
    logic               r_tag_v  [PWL_LAT];
    logic [ID_W-1:0]    r_tag_id [PWL_LAT];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_y;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_desync;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_x = '0;
        if (w_any) w_x = bus.req_x[w_idx*DATA_W +: DATA_W];
    end

    assign bus.req_ready    = w_gnt;
    assign bus.pwl_valid_in = w_any;
    assign bus.pwl_x_in     = w_x;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_y        = r_rsp_y;
    assign bus.issue_cnt    = r_cnt;
    assign bus.desync_err   = r_desync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
            r_cnt       <= '0;
            r_desync    <= 1'b0;
            for (int k = 0; k < PWL_LAT; k++) begin
                r_tag_v[k]  <= 1'b0;
                r_tag_id[k] <= '0;
            end
        end else begin
            if (w_any) begin
                r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            end

            // Tag pipe mirrors the unit's latency so its last stage lines up with pwl_valid_out.
            r_tag_v[0]  <= w_any;
            r_tag_id[0] <= w_idx;
            for (int k = 1; k < PWL_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end

            if (r_tag_v[PWL_LAT-1]) begin
                r_rsp_valid <= NUM_REQ'(1) << r_tag_id[PWL_LAT-1];
                r_rsp_id    <= r_tag_id[PWL_LAT-1];
                r_rsp_y     <= bus.pwl_y_out;
            end else begin
                r_rsp_valid <= '0;
            end

            if (bus.pwl_valid_out != r_tag_v[PWL_LAT-1]) r_desync <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwl_act_sched.sv
// Scoreboard bench for pwl_act_sched with a behavioural 5-segment Q8.8 sigmoid as the PWL unit.
module tb_pwl_act_sched;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_force = 1'b0;
    logic r_pv;
    logic [15:0] r_py;
    logic r_pv4;

    int errors = 0;
    int checks = 0;
    exp_t q[$];
    logic [15:0] lane_x [4];

    pwl_act_sched_if #(.NUM_REQ(4), .DATA_W(16), .CNT_W(16)) u_if ();
    pwl_act_sched_if #(.NUM_REQ(4), .DATA_W(16), .CNT_W(4))  u_if4 ();

    pwl_act_sched #(.NUM_REQ(4), .DATA_W(16), .PWL_LAT(1), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    pwl_act_sched #(.NUM_REQ(4), .DATA_W(16), .PWL_LAT(1), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4)
    );

    always #5 clk = ~clk;

    // Segments: flat 0 / slope 1/8 / slope 15/64 / slope 1/8 / flat 1.0, odd-symmetric about 0.5.
    function automatic logic [15:0] sig5(input logic [15:0] x);
        int xi, a, f;
        xi = int'($signed(x));
        a  = (xi < 0) ? -xi : xi;
        if (a <= 256)      f = 128 + ((a * 15) >>> 6);
        else if (a < 768)  f = 188 + ((a - 256) >>> 3);
        else               f = 256;
        return (xi < 0) ? 16'(256 - f) : 16'(f);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv  <= 1'b0;
            r_py  <= '0;
            r_pv4 <= 1'b0;
        end else begin
            r_pv  <= u_if.pwl_valid_in;
            r_py  <= sig5(u_if.pwl_x_in);
            r_pv4 <= u_if4.pwl_valid_in;
        end
    end

    assign u_if.pwl_valid_out  = r_pv | r_force;
    assign u_if.pwl_y_out      = r_py;
    assign u_if4.pwl_valid_out = r_pv4;
    assign u_if4.pwl_y_out     = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Monitor: every result the DUT presents must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && u_if.rsp_valid != 4'b0000) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'(u_if.rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", 32'(u_if.rsp_id), 32'(e.id));
                chk("rsp_onehot", 32'(u_if.rsp_valid), 32'(4'b0001 << e.id));
                chk("rsp_y", 32'(u_if.rsp_y), 32'(e.y));
            end
        end
    end

    task automatic step(input logic [3:0] v, input logic [3:0] exp_g, input logic [15:0] exp_y,
                        input bit push);
        logic [15:0] ex;
        @(posedge clk);
        #1;
        u_if.req_valid = v;
        @(negedge clk);
        ex = (exp_g != 4'b0000) ? lane_x[id_of(exp_g)] : 16'h0000;
        chk("req_ready", 32'(u_if.req_ready), 32'(exp_g));
        chk("pwl_valid_in", 32'(u_if.pwl_valid_in), 32'(v != 4'b0000));
        chk("pwl_x_in", 32'(u_if.pwl_x_in), 32'(ex));
        if (push && exp_g != 4'b0000) q.push_back('{id: id_of(exp_g), y: exp_y});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        u_if.req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        lane_x[0] = 16'h0000;
        lane_x[1] = 16'h0100;
        lane_x[2] = 16'hFF00;
        lane_x[3] = 16'd1000;
        u_if.req_valid  = 4'b0000;
        u_if.req_x      = {16'd1000, 16'hFF00, 16'h0100, 16'h0000};
        u_if4.req_valid = 4'b0000;
        u_if4.req_x     = '0;

        @(negedge clk);
        chk("rst_rsp_valid", 32'(u_if.rsp_valid), 32'h0);
        chk("rst_issue_cnt", 32'(u_if.issue_cnt), 32'h0);
        chk("rst_desync", 32'(u_if.desync_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lane 0 alone, x=0: result 0.5 two cycles after the handshake.
        step(4'b0001, 4'b0001, 16'd128, 1'b1);
        step(4'b0000, 4'b0000, 16'd0, 1'b0);
        chk("lat_early", 32'(u_if.rsp_valid), 32'h0);
        step(4'b0000, 4'b0000, 16'd0, 1'b0);
        chk("lat_on_time", 32'(u_if.rsp_valid), 32'h1);
        do_reset();

        // All lanes valid: strict rotation.
        step(4'b1111, 4'b0001, 16'd128, 1'b1);
        step(4'b1111, 4'b0010, 16'd188, 1'b1);
        step(4'b1111, 4'b0100, 16'd68, 1'b1);
        step(4'b1111, 4'b1000, 16'd256, 1'b1);
        // Lane 2 alone moves the pointer to 3, then lanes 2 and 3 alternate.
        step(4'b0100, 4'b0100, 16'd68, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1100, 4'b1000, 16'd256, 1'b1);
            step(4'b1100, 4'b0100, 16'd68, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 16'd0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("issue_cnt_11", 32'(u_if.issue_cnt), 32'd11);
        chk("no_desync", 32'(u_if.desync_err), 32'h0);

        // Reset with one op in flight: nothing may emerge afterwards.
        step(4'b0010, 4'b0010, 16'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        u_if.req_valid = 4'b0000;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(u_if.rsp_valid), 32'h0);
        chk("midrst_rsp_id", 32'(u_if.rsp_id), 32'h0);
        chk("midrst_rsp_y", 32'(u_if.rsp_y), 32'h0);
        chk("midrst_issue_cnt", 32'(u_if.issue_cnt), 32'h0);
        chk("midrst_ready", 32'(u_if.req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_rsp_valid", 32'(u_if.rsp_valid), 32'h0);
        end

        // Spurious result strobe with an empty tag pipe.
        @(posedge clk);
        #1;
        r_force = 1'b1;
        @(posedge clk);
        #1;
        r_force = 1'b0;
        @(negedge clk);
        chk("desync_set", 32'(u_if.desync_err), 32'h1);
        chk("desync_no_rsp", 32'(u_if.rsp_valid), 32'h0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("desync_sticky", 32'(u_if.desync_err), 32'h1);
        do_reset();
        @(negedge clk);
        chk("desync_cleared", 32'(u_if.desync_err), 32'h0);

        // 4-bit counter saturates at 15.
        @(posedge clk);
        #1;
        u_if4.req_valid = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 10) chk("cnt4_at_10", 32'(u_if4.issue_cnt), 32'd10);
            if (i == 20) chk("cnt4_sat", 32'(u_if4.issue_cnt), 32'd15);
        end
        chk("cnt4_ready", 32'(u_if4.req_ready), 32'h1);
        chk("cnt4_no_desync", 32'(u_if4.desync_err), 32'h0);
        u_if4.req_valid = 4'b0000;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
